bldc_gate_driver: RTL and testbench
===================================

// Module: bldc_gate_driver
// PURPOSE
//  Output stage between the hall/commutation logic and the six half-bridge gate pins (INHA..INLC).
//  Maps a commutation step and direction to a high-side/low-side pattern and gates high sides with the PWM.
//  Inserts dead time on every pattern change and latches a filtered FAULT_N.
//  All gates are forced off while a fault is latched.
// PARAMETERS
//  DEAD_CYCLES   1024  clk cycles all gates held off after any pattern change (>=1)
//  FAULT_FILTER  16    consecutive synchronized-low fault_n samples needed to latch a fault (>=1)
//  CNT_W         11    width of dead-time counter; must hold DEAD_CYCLES
// PORTS
//  clk          in   1  system clock (16 MHz)
//  reset_n      in   1  asynchronous active-low reset
//  enable       in   1  1 = drive bridge; 0 = target pattern all-off
//  dir          in   1  1 = forward table, 0 = reverse table
//  comm_state   in   3  commutation step 0..5; 6,7 = invalid
//  pwm_in       in   1  PWM from the pwm block; ANDed onto active high side
//  fault_n      in   1  driver fault pin, async, active low
//  clear_fault  in   1  1-cycle pulse, clears latched fault
//  inh          out  3  high-side gates {C,B,A}, registered
//  inl          out  3  low-side gates {C,B,A}, registered
//  fault        out  1  latched fault flag
//  dead         out  1  1 while in DEAD state
// BEHAVIOUR
//  Reset: inh=0, inl=0, fault=0, dead=1, FSM=DEAD, counter=DEAD_CYCLES, applied pattern=all-off, sync flops=1.
//  Target pattern (6 bits HA,LA,HB,LB,HC,LC), combinational from enable/dir/comm_state:
//   dir=1: 0:AH+BL 1:AH+CL 2:BH+CL 3:BH+AL 4:CH+AL 5:CH+BL
//   dir=0: 0:BH+AL 1:CH+AL 2:CH+BL 3:AH+BL 4:AH+CL 5:BH+CL
//   comm_state 6/7 or enable=0 -> all-off.
//  fault_n passes a 2-flop synchronizer, then a filter counter.
//   The counter increments while the synced value is 0 and clears to 0 when it is 1.
//   When the count reaches FAULT_FILTER: fault<=1 and FSM->FAULT.
//  FSM states RUN, DEAD, FAULT:
//   RUN: if target != applied -> DEAD, counter<=DEAD_CYCLES, outputs 0 next cycle.
//        Otherwise inh = applied_H & {3{pwm_in}} and inl = applied_L, registered (1-cycle latency from pwm_in).
//   DEAD: inh=inl=0. Counter decrements each cycle.
//        If target changes during DEAD, counter reloads to DEAD_CYCLES; persistent chatter may hold DEAD indefinitely.
//        At counter==1 and target stable: applied<=target, FSM->RUN.
//        First drive occurs DEAD_CYCLES+1 cycles after the last target change.
//   FAULT: inh=inl=0, dead=0.
//        Exits only when clear_fault=1 and synced fault_n=1: fault<=0, FSM->DEAD, counter reload, applied<=all-off.
//        clear_fault while fault_n is still low is ignored.
//  Priority in one cycle: fault latch > clear_fault > pattern change > dead count.
//  Invariants on every cycle:
//   - never inh[x]&inl[x] for the same phase x;
//   - never two phases with H set, never two with L set;
//   - a gate turning on is always preceded by >=DEAD_CYCLES cycles of all-off.
//  A switch to an all-off target still passes through DEAD; outputs are off the next cycle, with no delayed off.
//  reset_n asserted mid-operation: outputs drop to 0 asynchronously and the FSM restarts in DEAD.
// TESTING
//  1. DEAD_CYCLES=8. Release reset with enable=1, dir=1, comm_state=0, pwm_in=1.
//     -> inh=inl=0 for 9 cycles, then inh=3'b001, inl=3'b010.
//  2. In RUN state 0, step comm_state to 1.
//     -> next cycle inh=inl=0, dead=1; after 9 cycles inh=3'b001, inl=3'b100.
//  3. Toggle pwm_in 1/0 every cycle in RUN state 2, dir=1.
//     -> inh[1] follows pwm_in delayed 1 cycle; inl=3'b100 constant.
//  4. Hold fault_n=0 for 15 cycles then release -> no fault.
//     Hold fault_n=0 for 16 synced cycles -> fault=1, inh=inl=0.
//     Pulse clear_fault while fault_n=0 -> stays fault.
//     Release fault_n, then pulse clear_fault -> DEAD, then RUN after 9 cycles.
//  5. Toggle comm_state 0<->1 every 4 cycles during DEAD with DEAD_CYCLES=8.
//     -> outputs stay 0 throughout; after toggling stops, drive resumes 9 cycles later.
//  6. comm_state=7 or enable=0 in RUN -> all gates 0 next cycle.
//     Assertion across all tests: no shoot-through (inh[x]&inl[x]==0).

Source files
------------

// File: rtl/bldc_gate_driver_if.sv
// bldc_gate_driver_if: commutation command, PWM and fault inputs plus gate outputs of the gate driver
interface bldc_gate_driver_if;
  logic       enable;
  logic       dir;
  logic [2:0] comm_state;
  logic       pwm_in;
  logic       fault_n;
  logic       clear_fault;
  logic [2:0] inh;
  logic [2:0] inl;
  logic       fault;
  logic       dead;
  modport master (
    output enable, dir, comm_state, pwm_in, fault_n, clear_fault,
    input  inh, inl, fault, dead
  );
  modport slave (
    input  enable, dir, comm_state, pwm_in, fault_n, clear_fault,
    output inh, inl, fault, dead
  );
endinterface

// File: rtl/bldc_gate_driver.sv
// bldc_gate_driver: maps commutation step to half-bridge gates with dead time and a filtered, latched fault
module bldc_gate_driver #(
  parameter int DEAD_CYCLES  = 1024,
  parameter int FAULT_FILTER = 16,
  parameter int CNT_W        = 11
) (
  input logic               clk,
  input logic               reset_n,
  bldc_gate_driver_if.slave drv
);
  localparam int FW = $clog2(FAULT_FILTER + 1);
  typedef enum logic [1:0] {RUN, DEAD, FAULT} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       app_q, app_d, tgt_q, tgt;
  logic             arm_q;
  logic [1:0]       sync_q;
  logic [FW-1:0]    filt_q, filt_d;
  logic             fault_q, fault_d;
  logic [2:0]       inh_q, inh_d, inl_q, inl_d;
  logic             synced, trip, chg, drive;
  assign synced = sync_q[1];
  assign trip   = !synced && filt_q >= FW'(FAULT_FILTER - 1);
  assign chg    = arm_q && tgt != tgt_q;
  assign filt_d = synced ? '0 : (filt_q == FW'(FAULT_FILTER) ? filt_q : filt_q + 1'b1);
  // target pattern {H[C:A], L[C:A]} from direction and commutation step
  always_comb begin
    tgt = '0;
    if (drv.enable)
      case ({drv.dir, drv.comm_state})
        4'b1000, 4'b0011: tgt = 6'b001_010;
        4'b1001, 4'b0100: tgt = 6'b001_100;
        4'b1010, 4'b0101: tgt = 6'b010_100;
        4'b1011, 4'b0000: tgt = 6'b010_001;
        4'b1100, 4'b0001: tgt = 6'b100_001;
        4'b1101, 4'b0010: tgt = 6'b100_010;
        default:          tgt = '0;
      endcase
  end
  // state, dead counter, applied pattern, fault filter and registered gates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DEAD;
      cnt_q   <= CNT_W'(DEAD_CYCLES);
      app_q   <= '0;
      tgt_q   <= '0;
      arm_q   <= 1'b0;
      sync_q  <= 2'b11;
      filt_q  <= '0;
      fault_q <= 1'b0;
      inh_q   <= '0;
      inl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      app_q   <= app_d;
      tgt_q   <= tgt;
      arm_q   <= 1'b1;
      sync_q  <= {sync_q[0], drv.fault_n};
      filt_q  <= filt_d;
      fault_q <= fault_d;
      inh_q   <= inh_d;
      inl_q   <= inl_d;
    end
  end
  // next state: fault latch beats clear, clear beats pattern change, change beats dead count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    app_d   = app_q;
    fault_d = fault_q;
    if (trip) begin
      state_d = FAULT;
      fault_d = 1'b1;
    end else if (state_q == FAULT) begin
      if (drv.clear_fault && synced) begin
        state_d = DEAD;
        cnt_d   = CNT_W'(DEAD_CYCLES);
        app_d   = '0;
        fault_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      if (tgt != app_q) begin
        state_d = DEAD;
        cnt_d   = CNT_W'(DEAD_CYCLES);
      end
    end else if (chg) begin
      cnt_d = CNT_W'(DEAD_CYCLES);
    end else if (cnt_q == CNT_W'(1)) begin
      state_d = RUN;
      app_d   = tgt;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  // gates drive only in a stable RUN; any change or fault turns them off on the next edge
  always_comb begin
    drive = state_q == RUN && tgt == app_q && !trip;
    inh_d = drive ? app_q[5:3] & {3{drv.pwm_in}} : 3'b000;
    inl_d = drive ? app_q[2:0] : 3'b000;
  end
  assign drv.inh   = inh_q;
  assign drv.inl   = inl_q;
  assign drv.fault = fault_q;
  assign drv.dead  = state_q == DEAD;
endmodule

// File: tb/tb_bldc_gate_driver.sv
// tb_bldc_gate_driver: directed and randomized checks of the gate driver against a behavioural model
module tb_bldc_gate_driver;
  localparam int DC = 8;
  localparam int FF = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bldc_gate_driver_if bus ();
  bldc_gate_driver #(.DEAD_CYCLES(DC), .FAULT_FILTER(FF), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .drv(bus)
  );
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  bit m_fault, m_first;
  int m_since, m_low;
  logic [5:0] m_prev;
  bit m_q[$];
  logic [2:0] e_inh, e_inl;
  logic e_fault, e_dead;
  // step 0..5 walks high phase A,A,B,B,C,C; reverse is the forward table shifted by three steps
  function automatic logic [5:0] pat(input logic en, input logic d, input logic [2:0] cs);
    int s;
    if (!en || cs > 3'd5) return 6'b0;
    s = d ? int'(cs) : (int'(cs) + 3) % 6;
    return {3'(1 << (s / 2)), 3'(1 << (((s + 1) / 2 + 1) % 3))};
  endfunction
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_init();
    m_fault = 1'b0;
    m_first = 1'b1;
    m_since = 0;
    m_low   = 0;
    m_q     = '{1'b1, 1'b1};
    e_inh   = 3'b0;
    e_inl   = 3'b0;
    e_fault = 1'b0;
    e_dead  = 1'b1;
  endtask
  // drive is allowed once more than DC edges have passed since the last disturbance
  task automatic model_edge();
    logic [5:0] t;
    bit s, ch;
    t = pat(bus.enable, bus.dir, bus.comm_state);
    m_q.push_back(bus.fault_n);
    s = m_q.pop_front();
    m_low = s ? 0 : m_low + 1;
    ch = !m_first && t != m_prev;
    m_prev = t;
    m_first = 1'b0;
    if (m_low >= FF) m_fault = 1'b1;
    else if (m_fault) begin
      if (bus.clear_fault && s) begin
        m_fault = 1'b0;
        m_since = 0;
      end
    end else m_since = ch ? 0 : m_since + 1;
    e_inh   = (!m_fault && m_since > DC) ? t[5:3] & {3{bus.pwm_in}} : 3'b0;
    e_inl   = (!m_fault && m_since > DC) ? t[2:0] : 3'b0;
    e_fault = m_fault;
    e_dead  = !m_fault && m_since < DC;
  endtask
  task automatic check_all();
    chk("inh", {1'b0, bus.inh}, {1'b0, e_inh});
    chk("inl", {1'b0, bus.inl}, {1'b0, e_inl});
    chk("fault", {3'b0, bus.fault}, {3'b0, e_fault});
    chk("dead", {3'b0, bus.dead}, {3'b0, e_dead});
    chk("shoot_through", {1'b0, bus.inh & bus.inl}, 4'h0);
    chk("one_hot", {2'b0, $countones(bus.inh) > 1, $countones(bus.inl) > 1}, 4'h0);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  initial begin
    int burst;
    burst = 0;
    bus.enable = 1'b1;
    bus.dir = 1'b1;
    bus.comm_state = 3'd0;
    bus.pwm_in = 1'b1;
    bus.fault_n = 1'b1;
    bus.clear_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inh", {1'b0, bus.inh}, 4'h0);
    chk("rst_inl", {1'b0, bus.inl}, 4'h0);
    chk("rst_fault", {3'b0, bus.fault}, 4'h0);
    chk("rst_dead", {3'b0, bus.dead}, 4'h1);
    reset_n = 1'b1;
    model_init();
    repeat (8) tick();
    chk("t1_off", {1'b0, bus.inh}, 4'h0);
    tick();
    chk("t1_inh", {1'b0, bus.inh}, 4'h1);
    chk("t1_inl", {1'b0, bus.inl}, 4'h2);
    bus.comm_state = 3'd1;
    tick();
    chk("t2_dead", {3'b0, bus.dead}, 4'h1);
    chk("t2_off", {1'b0, bus.inh | bus.inl}, 4'h0);
    repeat (8) tick();
    chk("t2_still_off", {1'b0, bus.inh | bus.inl}, 4'h0);
    tick();
    chk("t2_inh", {1'b0, bus.inh}, 4'h1);
    chk("t2_inl", {1'b0, bus.inl}, 4'h4);
    bus.comm_state = 3'd2;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      bus.pwm_in = i[0];
      tick();
      chk("t3_pwm", {1'b0, bus.inh}, {2'b0, i[0], 1'b0});
      chk("t3_inl", {1'b0, bus.inl}, 4'h4);
    end
    bus.pwm_in = 1'b1;
    bus.fault_n = 1'b0;
    repeat (15) tick();
    bus.fault_n = 1'b1;
    repeat (20) tick();
    chk("t4_short_low", {3'b0, bus.fault}, 4'h0);
    bus.fault_n = 1'b0;
    repeat (17) tick();
    chk("t4_pre_latch", {3'b0, bus.fault}, 4'h0);
    tick();
    chk("t4_latch", {3'b0, bus.fault}, 4'h1);
    chk("t4_gates_off", {1'b0, bus.inh | bus.inl}, 4'h0);
    chk("t4_not_dead", {3'b0, bus.dead}, 4'h0);
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    chk("t4_clear_ignored", {3'b0, bus.fault}, 4'h1);
    bus.fault_n = 1'b1;
    repeat (3) tick();
    chk("t4_held", {3'b0, bus.fault}, 4'h1);
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    chk("t4_cleared", {3'b0, bus.fault}, 4'h0);
    chk("t4_dead", {3'b0, bus.dead}, 4'h1);
    repeat (8) tick();
    chk("t4_wait", {1'b0, bus.inh | bus.inl}, 4'h0);
    tick();
    chk("t4_resume_inh", {1'b0, bus.inh}, 4'h2);
    chk("t4_resume_inl", {1'b0, bus.inl}, 4'h4);
    for (int i = 0; i < 6; i++) begin
      bus.comm_state = i[0] ? 3'd1 : 3'd0;
      repeat (4) begin
        tick();
        chk("t5_chatter_off", {1'b0, bus.inh | bus.inl}, 4'h0);
      end
    end
    repeat (5) tick();
    chk("t5_wait", {1'b0, bus.inh | bus.inl}, 4'h0);
    tick();
    chk("t5_inh", {1'b0, bus.inh}, 4'h1);
    chk("t5_inl", {1'b0, bus.inl}, 4'h4);
    bus.comm_state = 3'd7;
    tick();
    chk("t6_invalid_off", {1'b0, bus.inh | bus.inl}, 4'h0);
    bus.comm_state = 3'd0;
    repeat (10) tick();
    chk("t6_run_inh", {1'b0, bus.inh}, 4'h1);
    bus.enable = 1'b0;
    tick();
    chk("t6_disable_off", {1'b0, bus.inh | bus.inl}, 4'h0);
    bus.enable = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_inh", {1'b0, bus.inh}, 4'h0);
    chk("arst_inl", {1'b0, bus.inl}, 4'h0);
    chk("arst_dead", {3'b0, bus.dead}, 4'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_init();
    repeat (8) tick();
    tick();
    chk("arst_resume_inh", {1'b0, bus.inh}, 4'h1);
    chk("arst_resume_inl", {1'b0, bus.inl}, 4'h2);
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) begin
        bus.comm_state = 3'($urandom_range(0, 7));
        bus.dir = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 40) == 0) bus.enable = ~bus.enable;
      bus.pwm_in = 1'($urandom_range(0, 1));
      if (burst > 0) begin
        burst--;
        bus.fault_n = 1'b0;
      end else begin
        bus.fault_n = 1'b1;
        if ($urandom_range(0, 150) == 0) burst = int'($urandom_range(4, 30));
      end
      bus.clear_fault = $urandom_range(0, 9) == 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
